// File: rtl/sdff_scan_bank_pkg.sv
// Shared types for the scan flop bank: operating mode and its decode from SE/EN.
package sdff_scan_bank_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10
    } sdff_mode_e;

    // Ternaries rather than a case so an X on se/en propagates into the mode.
    function automatic sdff_mode_e sdff_mode(input logic se, input logic en);
        return se ? MODE_SHIFT : (en ? MODE_LOAD : MODE_HOLD);
    endfunction

endpackage

// File: rtl/sdff_scan_bank_cell.sv
// One bit of the scan bank: async reset/set flop with shift/load/hold next-state mux.
module sdff_scan_bank_cell
    import sdff_scan_bank_pkg::*;
#(
    parameter logic RV = 1'b0,
    parameter logic SV = 1'b1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       setb,
    input  sdff_mode_e mode,
    input  logic       d,
    input  logic       si,
    output logic       q
);

    logic nxt;

    // Nested ternaries merge agreeing candidates when mode is unknown.
    assign nxt = (mode == MODE_SHIFT) ? si : ((mode == MODE_LOAD) ? d : q);

    always_ff @(posedge clk or negedge rstb or negedge setb) begin
        if (!rstb)      q <= RV;
        else if (!setb) q <= SV;
        else            q <= nxt;
    end

endmodule

// File: rtl/sdff_scan_bank.sv
// WIDTH-bit scan flop bank with internal chain, shift counter and done pulse.
// Define SDFF_SCAN_BANK_LOCKUP_EN to drive SO from a negedge lockup stage.
module sdff_scan_bank
    import sdff_scan_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    localparam int              CW      = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             SETB,
    input  logic             SE,
    input  logic             SI,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             SO,
    output logic [CW-1:0]    SHIFT_CNT,
    output logic             SHIFT_DONE
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("sdff_scan_bank: WIDTH out of range");
    end

    sdff_mode_e       mode;
    logic [WIDTH-1:0] sin;

    assign mode = sdff_mode(SE, EN);
    assign sin  = {Q[WIDTH-2:0], SI};
    assign QN   = ~Q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sdff_scan_bank_cell #(
            .RV (RST_VAL[i]),
            .SV (SET_VAL[i])
        ) u_cell (
            .clk  (CLK),
            .rstb (RSTB),
            .setb (SETB),
            .mode (mode),
            .d    (D[i]),
            .si   (sin[i]),
            .q    (Q[i])
        );
    end

    // Counter restarts whenever SE is low, so an aborted shift never pulses done.
    always_ff @(posedge CLK or negedge RSTB or negedge SETB) begin
        if (!RSTB || !SETB) begin
            SHIFT_CNT  <= '0;
            SHIFT_DONE <= 1'b0;
        end else if (SE) begin
            SHIFT_CNT  <= (SHIFT_CNT == LAST) ? '0 : SHIFT_CNT + 1'b1;
            SHIFT_DONE <= (SHIFT_CNT == LAST);
        end else begin
            SHIFT_CNT  <= '0;
            SHIFT_DONE <= 1'b0;
        end
    end

`ifdef SDFF_SCAN_BANK_LOCKUP_EN
    logic so_q;

    always_ff @(negedge CLK or negedge RSTB or negedge SETB) begin
        if (!RSTB)      so_q <= RST_VAL[WIDTH-1];
        else if (!SETB) so_q <= SET_VAL[WIDTH-1];
        else            so_q <= Q[WIDTH-1];
    end

    assign SO = so_q;
`else
    assign SO = Q[WIDTH-1];
`endif

endmodule

// File: tb/tb_sdff_scan_bank.sv
// Directed bench for sdff_scan_bank: WIDTH=8 and WIDTH=5 instances driven in lockstep.
module tb_sdff_scan_bank;

    localparam int R5 = 10;  // 5'h0A
    localparam int S5 = 21;  // 5'h15

    logic       CLK, clk_en;
    logic       RSTB, SETB, SE, SI, EN;
    logic [7:0] D8;
    logic [4:0] D5;
    logic [7:0] q8, qn8;
    logic [4:0] q5, qn5;
    logic [2:0] cnt8, cnt5;
    logic       so8, so5, done8, done5;

    int n_chk  = 0;
    int n_fail = 0;

    // Spec-level model: register values as integers, counters mod WIDTH.
    int m8_q, m8_cnt, m8_done, m5_q, m5_cnt, m5_done;
    int m8_so, m5_so;

    sdff_scan_bank #(.WIDTH(8), .RST_VAL(8'h00), .SET_VAL(8'hFF)) u_w8 (
        .CLK(CLK), .RSTB(RSTB), .SETB(SETB), .SE(SE), .SI(SI), .EN(EN), .D(D8),
        .Q(q8), .QN(qn8), .SO(so8), .SHIFT_CNT(cnt8), .SHIFT_DONE(done8)
    );

    sdff_scan_bank #(.WIDTH(5), .RST_VAL(5'h0A), .SET_VAL(5'h15)) u_w5 (
        .CLK(CLK), .RSTB(RSTB), .SETB(SETB), .SE(SE), .SI(SI), .EN(EN), .D(D5),
        .Q(q5), .QN(qn5), .SO(so5), .SHIFT_CNT(cnt5), .SHIFT_DONE(done5)
    );

    always #5 if (clk_en) CLK = ~CLK;

    always @(posedge CLK or negedge RSTB or negedge SETB) begin
        if (!RSTB) begin
            m8_q = 0;   m8_cnt = 0; m8_done = 0;
            m5_q = R5;  m5_cnt = 0; m5_done = 0;
        end else if (!SETB) begin
            m8_q = 255; m8_cnt = 0; m8_done = 0;
            m5_q = S5;  m5_cnt = 0; m5_done = 0;
        end else if (SE) begin
            m8_done = (m8_cnt == 7) ? 1 : 0;
            m5_done = (m5_cnt == 4) ? 1 : 0;
            m8_cnt  = (m8_cnt + 1) % 8;
            m5_cnt  = (m5_cnt + 1) % 5;
            m8_q    = (m8_q * 2 + int'(SI)) % 256;
            m5_q    = (m5_q * 2 + int'(SI)) % 32;
        end else begin
            m8_done = 0; m8_cnt = 0;
            m5_done = 0; m5_cnt = 0;
            if (EN) begin
                m8_q = int'(D8);
                m5_q = int'(D5);
            end
        end
    end

`ifdef SDFF_SCAN_BANK_LOCKUP_EN
    always @(negedge CLK or negedge RSTB or negedge SETB) begin
        if (!RSTB) begin
            m8_so = 0; m5_so = R5 / 16;
        end else if (!SETB) begin
            m8_so = 1; m5_so = S5 / 16;
        end else begin
            m8_so = m8_q / 128; m5_so = m5_q / 16;
        end
    end
`else
    always_comb begin
        m8_so = m8_q / 128;
        m5_so = m5_q / 16;
    end
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("q8",    64'(q8),    64'(m8_q));
        chk("qn8",   64'(qn8),   64'(255 - m8_q));
        chk("so8",   64'(so8),   64'(m8_q / 128));
        chk("cnt8",  64'(cnt8),  64'(m8_cnt));
        chk("done8", 64'(done8), 64'(m8_done));
        chk("q5",    64'(q5),    64'(m5_q));
        chk("qn5",   64'(qn5),   64'(31 - m5_q));
        chk("so5",   64'(so5),   64'(m5_q / 16));
        chk("cnt5",  64'(cnt5),  64'(m5_cnt));
        chk("done5", 64'(done5), 64'(m5_done));
    endtask

    // One clock: drive, check SO just after the rising edge, full compare after the falling edge.
    task automatic cyc(input logic se, input logic si, input logic en, input logic [7:0] d);
        SE = se; SI = si; EN = en; D8 = d; D5 = d[4:0];
        @(posedge CLK); #1;
        chk("so8_rise", 64'(so8), 64'(m8_so));
        chk("so5_rise", 64'(so5), 64'(m5_so));
        @(negedge CLK); #1;
        compare_all();
    endtask

    initial begin
        int nd8, nd5;
        logic [7:0] pat;
        CLK = 0; clk_en = 0;
        RSTB = 1; SETB = 1; SE = 0; SI = 0; EN = 0; D8 = '0; D5 = '0;

        // Async reset/set with the clock idle
        #1 RSTB = 0;
        #1 compare_all();
        chk("rst_q8", 64'(q8), 64'h00);
        chk("rst_qn8", 64'(qn8), 64'hFF);
        chk("rst_q5", 64'(q5), 64'h0A);
        RSTB = 1;
        #1 SETB = 0;
        #1 compare_all();
        chk("set_q8", 64'(q8), 64'hFF);
        chk("set_q5", 64'(q5), 64'h15);
        SETB = 1;
        #1 RSTB = 0; SETB = 0;
        #1 compare_all();
        chk("both_q8", 64'(q8), 64'h00);
        chk("both_q5", 64'(q5), 64'h0A);
        SETB = 1;
        #1 RSTB = 1;
        #1 compare_all();
        clk_en = 1;

        // Load then hold
        cyc(0, 0, 1, 8'hA5);
        chk("load_q8", 64'(q8), 64'hA5);
        chk("load_q5", 64'(q5), 64'h05);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h3C);
        chk("hold_q8", 64'(q8), 64'hA5);

        // Full shift from zero
        cyc(0, 0, 1, 8'h00);
        pat = 8'b1011_0010;
        nd8 = 0; nd5 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, pat[7-i], 0, 8'h00);
            nd8 += int'(done8); nd5 += int'(done5);
            if (i == 6) chk("cnt8_at7", 64'(cnt8), 64'd7);
        end
        chk("shift_q8", 64'(q8), 64'hB2);
        chk("shift_q5", 64'(q5), 64'h12);
        chk("shift_cnt8", 64'(cnt8), 64'd0);
        chk("shift_done8_cnt", 64'(nd8), 64'd1);
        chk("shift_done5_cnt", 64'(nd5), 64'd1);
        cyc(0, 0, 0, 8'h00);
        chk("done8_drop", 64'(done8), 64'd0);

        // Aborted shift
        nd8 = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 8'h00);
            nd8 += int'(done8);
        end
        cyc(0, 0, 0, 8'h00);
        nd8 += int'(done8);
        chk("abort_q8", 64'(q8), 64'h5F);
        chk("abort_cnt8", 64'(cnt8), 64'd0);
        chk("abort_done8", 64'(nd8), 64'd0);
        cyc(1, 0, 0, 8'h00);
        chk("restart_cnt8", 64'(cnt8), 64'd1);

        // Async set in the middle of a shift
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        chk("pre_set_cnt8", 64'(cnt8), 64'd3);
        SETB = 0;
        #2 compare_all();
        chk("midset_q8", 64'(q8), 64'hFF);
        chk("midset_cnt8", 64'(cnt8), 64'd0);
        SETB = 1;
        nd8 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 8'h00);
            nd8 += int'(done8);
        end
        chk("after_set_done8", 64'(nd8), 64'd1);
        chk("after_set_q8", 64'(q8), 64'h00);

        // Async reset in the middle of a shift
        cyc(1, 1, 0, 8'h00);
        cyc(1, 1, 0, 8'h00);
        RSTB = 0;
        #2 compare_all();
        chk("midrst_q5", 64'(q5), 64'h0A);
        chk("midrst_cnt8", 64'(cnt8), 64'd0);
        RSTB = 1;
        cyc(1, 1, 0, 8'h00);
        chk("post_rst_cnt8", 64'(cnt8), 64'd1);
        cyc(0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
